// File: rtl/uart_echo_fifo.sv
// rtl/uart_echo_fifo.sv - UART receiver feeding a FIFO that drives a UART transmitter (echo path)
`timescale 1ns/1ps
module uart_echo_fifo #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BIT_RATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_i,
  output logic                          tx_o,
  input  logic                          tx_en_i,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          overrun_o,
  output logic                          frame_err_o,
  output logic                          parity_err_o
);

  localparam int CLK_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT    = CLK_PER_BIT / 2;
  localparam int STOP_CYC    = STOP_BITS * CLK_PER_BIT;
  localparam int CNT_W       = $clog2(STOP_CYC + 1);
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int LVL_W       = PTR_W + 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYC - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);

  // Parity bit value a transmitter would send for this word.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : ^d;
  endfunction

  // ---------------------------------------------------------------- sync / arm
  logic       rx_meta, rx_sync, rx_prev, rx_armed;
  logic [1:0] flush;
  logic       rx_fall;

  // Arming waits until the synchroniser holds real line samples, so a line
  // held low through reset cannot masquerade as a start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      flush    <= 2'd0;
      rx_armed <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (flush != 2'd2) flush <= flush + 2'd1;
      if (flush == 2'd2 && rx_sync) rx_armed <= 1'b1;
    end
  end

  assign rx_fall = rx_armed && rx_prev && !rx_sync;

  // ---------------------------------------------------------------- RX FSM
  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_WAIT_HIGH
  } rx_state_t;

  rx_state_t              rx_state, rx_state_d;
  logic [CNT_W-1:0]       rx_cnt, rx_cnt_d;
  logic [3:0]             rx_bit, rx_bit_d;
  logic [DATA_BITS-1:0]   rx_shreg, rx_shreg_d;
  logic                   rx_par_bad, rx_par_bad_d;
  logic                   rx_tvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= R_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shreg   <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_bit     <= rx_bit_d;
      rx_shreg   <= rx_shreg_d;
      rx_par_bad <= rx_par_bad_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt + CNT_W'(1);
    rx_bit_d     = rx_bit;
    rx_shreg_d   = rx_shreg;
    rx_par_bad_d = rx_par_bad;
    rx_tvalid    = 1'b0;
    frame_err_o  = 1'b0;
    parity_err_o = 1'b0;
    case (rx_state)
      R_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d   = R_START;
          rx_par_bad_d = 1'b0;
        end
      end
      R_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shreg_d = {rx_sync, rx_shreg[DATA_BITS-1:1]};
          if (rx_bit == DATA_LAST)
            rx_state_d = (PARITY != 0) ? R_PARITY : R_STOP;
          else
            rx_bit_d = rx_bit + 4'd1;
        end
      end
      R_PARITY: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d     = '0;
          rx_par_bad_d = (rx_sync != parity_bit(rx_shreg));
          rx_state_d   = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_d     = '0;
          parity_err_o = rx_par_bad;
          frame_err_o  = !rx_sync;
          rx_tvalid    = rx_sync && !rx_par_bad;
          rx_state_d   = rx_sync ? R_IDLE : R_WAIT_HIGH;
        end
      end
      R_WAIT_HIGH: begin
        rx_cnt_d = '0;
        if (rx_sync) rx_state_d = R_IDLE;
      end
      default: begin
        rx_cnt_d   = '0;
        rx_state_d = R_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level;
  logic                 fifo_full, fifo_tvalid, fifo_tready, wr_ok;
  logic [DATA_BITS-1:0] fifo_tdata;

  assign fifo_full    = (level == LVL_W'(FIFO_DEPTH));
  assign fifo_tvalid  = (level != '0);
  assign fifo_tdata   = mem[rd_ptr];
  // A full FIFO still takes a word when the transmitter pops in the same cycle.
  assign wr_ok        = rx_tvalid && (!fifo_full || fifo_tready);
  assign overrun_o    = rx_tvalid && !wr_ok;
  assign fifo_level_o = level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok)       wr_ptr <= wr_ptr + PTR_W'(1);
      if (fifo_tready) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, fifo_tready})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= rx_shreg;
  end

  // ---------------------------------------------------------------- TX FSM
  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PARITY, T_STOP
  } tx_state_t;

  tx_state_t            tx_state, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_d;
  logic [3:0]           tx_bit, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shreg, tx_shreg_d;
  logic                 tx_par, tx_par_d;
  logic                 tx_q, tx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shreg <= tx_shreg_d;
      tx_par   <= tx_par_d;
      tx_q     <= tx_d;
    end
  end

  // tx_o is registered so the pin never sees decode glitches.
  always_comb begin
    tx_state_d  = tx_state;
    tx_cnt_d    = tx_cnt + CNT_W'(1);
    tx_bit_d    = tx_bit;
    tx_shreg_d  = tx_shreg;
    tx_par_d    = tx_par;
    tx_d        = tx_q;
    fifo_tready = 1'b0;
    case (tx_state)
      T_IDLE: begin
        tx_cnt_d = '0;
        tx_d     = 1'b1;
        if (fifo_tvalid && tx_en_i) begin
          fifo_tready = 1'b1;
          tx_shreg_d  = fifo_tdata;
          tx_par_d    = parity_bit(fifo_tdata);
          tx_state_d  = T_START;
          tx_d        = 1'b0;
        end
      end
      T_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_d       = tx_shreg[0];
          tx_state_d = T_DATA;
        end
      end
      T_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit == DATA_LAST) begin
            tx_state_d = (PARITY != 0) ? T_PARITY : T_STOP;
            tx_d       = (PARITY != 0) ? tx_par : 1'b1;
          end else begin
            tx_bit_d   = tx_bit + 4'd1;
            tx_shreg_d = {1'b0, tx_shreg[DATA_BITS-1:1]};
            tx_d       = tx_shreg[1];
          end
        end
      end
      T_PARITY: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = T_STOP;
        end
      end
      T_STOP: begin
        if (tx_cnt == STOP_LAST) begin
          tx_cnt_d   = '0;
          tx_d       = 1'b1;
          tx_state_d = T_IDLE;
        end
      end
      default: begin
        tx_cnt_d   = '0;
        tx_d       = 1'b1;
        tx_state_d = T_IDLE;
      end
    endcase
  end

  assign tx_o   = tx_q;
  assign busy_o = (tx_state != T_IDLE);

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb/tb_uart_echo_fifo.sv - directed self-checking bench for uart_echo_fifo (CLK_PER_BIT = 10)
`timescale 1ns/1ps
module tb_uart_echo_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] rx_w, tx_en_w;
  logic [3:0] tx_w, busy_w, ovr_w, ferr_w, perr_w;
  logic [4:0] lvl0, lvl1, lvl3;
  logic [2:0] lvl2;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt[4] = '{default: 0};
  int perr_cnt[4] = '{default: 0};
  int ovr_cnt[4]  = '{default: 0};
  int fall_cnt[4] = '{default: 0};
  int bfall_cyc[4] = '{default: 0};
  logic [3:0] tx_prev = 4'hF;
  logic [3:0] busy_prev = 4'h0;

  // u0: 8N1 depth 16, u1: 7E1, u2: 8N1 depth 4, u3: 8N2
  uart_echo_fifo #(.CLK_HZ(1_000_000), .BIT_RATE(100_000)) u0 (
    .clk(clk), .reset(reset), .rx_i(rx_w[0]), .tx_o(tx_w[0]), .tx_en_i(tx_en_w[0]),
    .busy_o(busy_w[0]), .fifo_level_o(lvl0), .overrun_o(ovr_w[0]),
    .frame_err_o(ferr_w[0]), .parity_err_o(perr_w[0]));
  uart_echo_fifo #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .DATA_BITS(7), .PARITY(2)) u1 (
    .clk(clk), .reset(reset), .rx_i(rx_w[1]), .tx_o(tx_w[1]), .tx_en_i(tx_en_w[1]),
    .busy_o(busy_w[1]), .fifo_level_o(lvl1), .overrun_o(ovr_w[1]),
    .frame_err_o(ferr_w[1]), .parity_err_o(perr_w[1]));
  uart_echo_fifo #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .reset(reset), .rx_i(rx_w[2]), .tx_o(tx_w[2]), .tx_en_i(tx_en_w[2]),
    .busy_o(busy_w[2]), .fifo_level_o(lvl2), .overrun_o(ovr_w[2]),
    .frame_err_o(ferr_w[2]), .parity_err_o(perr_w[2]));
  uart_echo_fifo #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .STOP_BITS(2)) u3 (
    .clk(clk), .reset(reset), .rx_i(rx_w[3]), .tx_o(tx_w[3]), .tx_en_i(tx_en_w[3]),
    .busy_o(busy_w[3]), .fifo_level_o(lvl3), .overrun_o(ovr_w[3]),
    .frame_err_o(ferr_w[3]), .parity_err_o(perr_w[3]));

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (tx_prev[i] && !tx_w[i]) fall_cnt[i]++;
      if (busy_prev[i] && !busy_w[i]) bfall_cyc[i] = cyc;
      if (ferr_w[i]) ferr_cnt[i]++;
      if (perr_w[i]) perr_cnt[i]++;
      if (ovr_w[i])  ovr_cnt[i]++;
    end
    tx_prev   = tx_w;
    busy_prev = busy_w;
  end

  function automatic int lvl(input int u);
    case (u)
      0: return int'(lvl0);
      1: return int'(lvl1);
      2: return int'(lvl2);
      3: return int'(lvl3);
      default: return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // bits[0] goes on the line first; each bit lasts 10 clocks
  task automatic send_bits(input int u, input logic [9:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_w[u] = bits[i];
      repeat (10) tick();
    end
  endtask

  task automatic wait_tx_fall(input int u, input int limit, output int f);
    int k;
    k = 0;
    while (tx_w[u] && k < limit) begin
      tick();
      k++;
    end
    f = tx_w[u] ? -1 : cyc;
  endtask

  // first and last clock of each of the 10 frame bits starting at cycle f
  task automatic capture(input int u, input int f, output logic [9:0] s, output logic [9:0] e);
    for (int j = 0; j < 10; j++) begin
      wait_until(f + 10 * j);
      s[j] = tx_w[u];
      wait_until(f + 10 * j + 9);
      e[j] = tx_w[u];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (tx_w !== 4'hF) begin n_bad++; $display("FAIL rst_tx got %b want 1111", tx_w); end
    n_cmp++; if (busy_w !== 4'h0) begin n_bad++; $display("FAIL rst_busy got %b want 0000", busy_w); end
    n_cmp++; if ({lvl0, lvl1, lvl2, lvl3} !== 18'd0) begin n_bad++; $display("FAIL rst_level got %0d/%0d/%0d/%0d want 0", lvl0, lvl1, lvl2, lvl3); end
    n_cmp++; if ({ovr_w, ferr_w, perr_w} !== 12'd0) begin n_bad++; $display("FAIL rst_pulses got %b want 0", {ovr_w, ferr_w, perr_w}); end
    reset = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_echo_8n1();
    int c0, f, fe0, pe0;
    logic [9:0] s, e;
    s = '0; e = '0; f = -1;
    fe0 = ferr_cnt[0]; pe0 = perr_cnt[0];
    c0 = cyc;
    fork
      send_bits(0, {1'b1, 8'hA5, 1'b0}, 10);
      begin
        wait_tx_fall(0, 300, f);
        if (f >= 0) capture(0, f, s, e);
      end
    join
    n_cmp++; if (f - c0 !== 99) begin n_bad++; $display("FAIL a5_latency got %0d want 99", f - c0); end
    n_cmp++; if (s !== 10'b1101001010) begin n_bad++; $display("FAIL a5_bits_first got %b want 1101001010", s); end
    n_cmp++; if (e !== 10'b1101001010) begin n_bad++; $display("FAIL a5_bits_last got %b want 1101001010", e); end
    wait_until(f + 102);
    n_cmp++; if (bfall_cyc[0] - f !== 100) begin n_bad++; $display("FAIL a5_busy_len got %0d want 100", bfall_cyc[0] - f); end
    n_cmp++; if (ferr_cnt[0] - fe0 + perr_cnt[0] - pe0 !== 0) begin n_bad++; $display("FAIL a5_errors got %0d want 0", ferr_cnt[0] - fe0 + perr_cnt[0] - pe0); end
    n_cmp++; if (lvl(0) !== 0) begin n_bad++; $display("FAIL a5_level got %0d want 0", lvl(0)); end
  endtask

  task automatic test_parity();
    int c0, f, pe0, fl0;
    logic [9:0] s, e;
    s = '0; e = '0; f = -1;
    pe0 = perr_cnt[1]; fl0 = fall_cnt[1];
    send_bits(1, {1'b1, 1'b1, 7'h03, 1'b0}, 10);
    repeat (30) tick();
    n_cmp++; if (perr_cnt[1] - pe0 !== 1) begin n_bad++; $display("FAIL par_err_pulses got %0d want 1", perr_cnt[1] - pe0); end
    n_cmp++; if (lvl(1) !== 0) begin n_bad++; $display("FAIL par_level got %0d want 0", lvl(1)); end
    n_cmp++; if (fall_cnt[1] !== fl0 || tx_w[1] !== 1'b1) begin n_bad++; $display("FAIL par_tx_quiet got falls %0d tx %b want 0 falls tx 1", fall_cnt[1] - fl0, tx_w[1]); end
    c0 = cyc;
    fork
      send_bits(1, {1'b1, 1'b0, 7'h03, 1'b0}, 10);
      begin
        wait_tx_fall(1, 300, f);
        if (f >= 0) capture(1, f, s, e);
      end
    join
    n_cmp++; if (f - c0 !== 99) begin n_bad++; $display("FAIL par_good_latency got %0d want 99", f - c0); end
    n_cmp++; if (s !== 10'b1000000110 || e !== 10'b1000000110) begin n_bad++; $display("FAIL par_good_bits got %b/%b want 1000000110", s, e); end
    n_cmp++; if (perr_cnt[1] - pe0 !== 1) begin n_bad++; $display("FAIL par_good_no_err got %0d want 1", perr_cnt[1] - pe0); end
    repeat (5) tick();
  endtask

  task automatic test_frame_err();
    int c0, f, fe0, pe0, fl0;
    logic [9:0] s, e;
    s = '0; e = '0; f = -1;
    fe0 = ferr_cnt[0]; pe0 = perr_cnt[0]; fl0 = fall_cnt[0];
    send_bits(0, {1'b0, 8'hFF, 1'b0}, 10);
    repeat (50) tick();
    rx_w[0] = 1'b1;
    repeat (20) tick();
    n_cmp++; if (ferr_cnt[0] - fe0 !== 1) begin n_bad++; $display("FAIL ferr_pulses got %0d want 1", ferr_cnt[0] - fe0); end
    n_cmp++; if (perr_cnt[0] - pe0 !== 0) begin n_bad++; $display("FAIL ferr_no_perr got %0d want 0", perr_cnt[0] - pe0); end
    n_cmp++; if (lvl(0) !== 0 || fall_cnt[0] !== fl0) begin n_bad++; $display("FAIL ferr_no_write got level %0d falls %0d want 0/0", lvl(0), fall_cnt[0] - fl0); end
    c0 = cyc;
    fork
      send_bits(0, {1'b1, 8'h3C, 1'b0}, 10);
      begin
        wait_tx_fall(0, 300, f);
        if (f >= 0) capture(0, f, s, e);
      end
    join
    n_cmp++; if (f - c0 !== 99) begin n_bad++; $display("FAIL ferr_next_latency got %0d want 99", f - c0); end
    n_cmp++; if (s !== 10'b1001111000 || e !== 10'b1001111000) begin n_bad++; $display("FAIL ferr_next_bits got %b/%b want 1001111000", s, e); end
    repeat (5) tick();
  endtask

  task automatic test_overrun();
    logic [7:0] words [5];
    logic [9:0] s, e;
    int ov0, cs, f, fprev;
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    tx_en_w[2] = 1'b0;
    ov0 = ovr_cnt[2];
    for (int i = 0; i < 4; i++) send_bits(2, {1'b1, words[i], 1'b0}, 10);
    n_cmp++; if (lvl(2) !== 4 || ovr_cnt[2] - ov0 !== 0) begin n_bad++; $display("FAIL ovr_fill got level %0d overruns %0d want 4/0", lvl(2), ovr_cnt[2] - ov0); end
    send_bits(2, {1'b1, words[4], 1'b0}, 10);
    n_cmp++; if (ovr_cnt[2] - ov0 !== 1) begin n_bad++; $display("FAIL ovr_pulses got %0d want 1", ovr_cnt[2] - ov0); end
    n_cmp++; if (lvl(2) !== 4) begin n_bad++; $display("FAIL ovr_level_full got %0d want 4", lvl(2)); end
    repeat (5) tick();
    cs = cyc;
    tx_en_w[2] = 1'b1;
    fprev = cs - 100;
    for (int k = 0; k < 4; k++) begin
      s = '0; e = '0;
      wait_tx_fall(2, 300, f);
      n_cmp++; if (f - fprev !== 101) begin n_bad++; $display("FAIL ovr_gap%0d got %0d want 101", k, f - fprev); end
      if (f >= 0) capture(2, f, s, e);
      n_cmp++; if (s !== {1'b1, words[k], 1'b0} || e !== {1'b1, words[k], 1'b0}) begin n_bad++; $display("FAIL ovr_word%0d got %b/%b want %b", k, s, e, {1'b1, words[k], 1'b0}); end
      fprev = f;
    end
    repeat (5) tick();
    n_cmp++; if (lvl(2) !== 0 || busy_w[2] !== 1'b0) begin n_bad++; $display("FAIL ovr_drain got level %0d busy %b want 0/0", lvl(2), busy_w[2]); end
  endtask

  task automatic test_stop2();
    int f;
    logic [9:0] s, e;
    s = '0; e = '0; f = -1;
    fork
      send_bits(3, {1'b1, 8'h00, 1'b0}, 10);
      begin
        wait_tx_fall(3, 300, f);
        if (f >= 0) capture(3, f, s, e);
      end
    join
    n_cmp++; if (s !== 10'b1000000000 || e !== 10'b1000000000) begin n_bad++; $display("FAIL stop2_bits got %b/%b want 1000000000", s, e); end
    wait_until(f + 109);
    n_cmp++; if (tx_w[3] !== 1'b1 || busy_w[3] !== 1'b1) begin n_bad++; $display("FAIL stop2_tail got tx %b busy %b want 1/1", tx_w[3], busy_w[3]); end
    wait_until(f + 110);
    n_cmp++; if (busy_w[3] !== 1'b0) begin n_bad++; $display("FAIL stop2_busy_drop got %b want 0", busy_w[3]); end
    tick();
    n_cmp++; if (bfall_cyc[3] - f !== 110) begin n_bad++; $display("FAIL stop2_busy_len got %0d want 110", bfall_cyc[3] - f); end
  endtask

  task automatic test_reset_mid_tx();
    int c0, f, fe0, fl0;
    logic [9:0] s, e;
    tx_en_w[0] = 1'b0;
    send_bits(0, {1'b1, 8'h12, 1'b0}, 10);
    send_bits(0, {1'b1, 8'h34, 1'b0}, 10);
    n_cmp++; if (lvl(0) !== 2) begin n_bad++; $display("FAIL rmid_prefill got %0d want 2", lvl(0)); end
    tx_en_w[0] = 1'b1;
    wait_tx_fall(0, 50, f);
    wait_until(f + 25);
    rx_w[0] = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp++; if (tx_w[0] !== 1'b1 || lvl(0) !== 0 || busy_w[0] !== 1'b0) begin n_bad++; $display("FAIL rmid_async got tx %b level %0d busy %b want 1/0/0", tx_w[0], lvl(0), busy_w[0]); end
    repeat (3) tick();
    reset = 1'b0;
    fe0 = ferr_cnt[0]; fl0 = fall_cnt[0];
    repeat (150) tick();
    n_cmp++; if (lvl(0) !== 0 || ferr_cnt[0] !== fe0 || fall_cnt[0] !== fl0) begin n_bad++; $display("FAIL rmid_low_line got level %0d ferr %0d falls %0d want 0/0/0", lvl(0), ferr_cnt[0] - fe0, fall_cnt[0] - fl0); end
    rx_w[0] = 1'b1;
    repeat (20) tick();
    s = '0; e = '0; f = -1;
    c0 = cyc;
    fork
      send_bits(0, {1'b1, 8'h7E, 1'b0}, 10);
      begin
        wait_tx_fall(0, 300, f);
        if (f >= 0) capture(0, f, s, e);
      end
    join
    n_cmp++; if (f - c0 !== 99) begin n_bad++; $display("FAIL rmid_latency got %0d want 99", f - c0); end
    n_cmp++; if (s !== 10'b1011111100 || e !== 10'b1011111100) begin n_bad++; $display("FAIL rmid_bits got %b/%b want 1011111100", s, e); end
    repeat (5) tick();
  endtask

  task automatic test_glitch();
    int fe0, pe0, fl0;
    fe0 = ferr_cnt[0]; pe0 = perr_cnt[0]; fl0 = fall_cnt[0];
    rx_w[0] = 1'b0;
    repeat (3) tick();
    rx_w[0] = 1'b1;
    repeat (60) tick();
    n_cmp++; if (ferr_cnt[0] !== fe0 || perr_cnt[0] !== pe0) begin n_bad++; $display("FAIL glitch_errors got %0d/%0d want 0/0", ferr_cnt[0] - fe0, perr_cnt[0] - pe0); end
    n_cmp++; if (lvl(0) !== 0 || fall_cnt[0] !== fl0) begin n_bad++; $display("FAIL glitch_write got level %0d falls %0d want 0/0", lvl(0), fall_cnt[0] - fl0); end
  endtask

  initial begin
    reset   = 1'b1;
    rx_w    = 4'hF;
    tx_en_w = 4'hF;
    tick();
    test_reset();
    test_echo_8n1();
    test_parity();
    test_frame_err();
    test_overrun();
    test_stop2();
    test_reset_mid_tx();
    test_glitch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
